// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole controller: state codes, LFSR constants, helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package game_pkg;

    // Game state encoding, visible on the state output
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAP  = 3'd1,
        ST_SHOW = 3'd2,
        ST_HIT  = 3'd3,
        ST_MISS = 3'd4,
        ST_OVER = 3'd5
    } game_state_e;

    // Reset value of the mole-selection LFSR (any non-zero value works)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Right-shifting Galois taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One Galois step: shift right, fold the output bit back through the taps
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] shifted;
        shifted = {1'b0, cur[15:1]};
        return cur[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

    // Map a random nibble to a mole position, bumping by one if it would
    // light the same mole twice in a row
    function automatic logic [3:0] pick_index(input logic [3:0]  raw,
                                              input logic [3:0]  prev,
                                              input int unsigned n);
        logic [4:0] lim;
        logic [4:0] idx;
        lim = 5'(n);
        idx = {1'b0, raw} % lim;
        if (idx[3:0] == prev) begin
            idx = ((idx + 5'd1) == lim) ? 5'd0 : (idx + 5'd1);
        end
        return idx[3:0];
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 16-bit Galois LFSR that free-runs every clock and supplies the random mole nibble.
// Latency: nibble reflects the current register; it advances one step per clock.
// Backpressure: none; it never stalls and is reseeded if it ever hits zero.
module mole_lfsr
    import game_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [3:0] nib_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Next value; the all-zero lock-up state is unreachable from a non-zero
    // seed, but fall back to the seed anyway so an upset cannot freeze it
    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
        if (lfsr_d == 16'h0000) begin
            lfsr_d = LFSR_SEED;
        end
    end

    // Step on every clock, seed while in reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign nib_o = lfsr_q[3:0];

endmodule

// File: rtl/game_fsm_n.sv
// Whack-a-mole game controller: gap/show timing, hit/miss scoring, lives and game-over.
// Latency: inputs are registered once, so a button press acts on the second clock edge.
// Backpressure: none; buttons and time_up are levels sampled every clock.
module game_fsm_n
    import game_pkg::*;
#(
    parameter int unsigned N_MOLES     = 4,
    parameter int unsigned MOLE_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 12_500_000,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_MOLES-1:0] whack,
    input  logic               time_up,
    output logic [2:0]         state,
    output logic [N_MOLES-1:0] mole,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         lives,
    output logic               hit_pulse,
    output logic               miss_pulse
);

    // Phase counter sized for the longer of the two timed phases
    localparam int unsigned CNT_MAX = (MOLE_CYCLES > GAP_CYCLES) ? MOLE_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Counter runs load..0, so a phase occupies exactly load+1 clocks
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(MOLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       LIVES_INIT = 4'(LIVES);
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

    // Input synchronising registers
    logic               start_q;
    logic               start_prev_q;
    logic [N_MOLES-1:0] whack_q;
    logic               time_up_q;

    // Game state
    game_state_e        state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SCORE_W-1:0] score_q;
    logic [3:0]         lives_q;
    logic [N_MOLES-1:0] mole_q;
    logic [3:0]         idx_q;
    logic               hit_pulse_q;
    logic               miss_pulse_q;

    // Candidate mole for the next SHOW entry
    logic [3:0]         idx_d;
    logic [N_MOLES-1:0] mole_d;
    logic [3:0]         lfsr_nib;

    logic start_rise;
    logic mole_hit;
    logic any_whack;

    mole_lfsr u_lfsr (
        .clk_i  (clk),
        .rst_ni (reset),
        .nib_o  (lfsr_nib)
    );

    // Register the raw buttons and timer once; keep last start for edge detect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            whack_q      <= '0;
            time_up_q    <= 1'b0;
        end else begin
            start_q      <= start;
            start_prev_q <= start_q;
            whack_q      <= whack;
            time_up_q    <= time_up;
        end
    end

    assign start_rise = start_q & ~start_prev_q;
    assign mole_hit   = |(whack_q & mole_q);
    assign any_whack  = |whack_q;

    // Pick the next mole from the LFSR, avoiding an immediate repeat of idx_q
    always_comb begin
        idx_d  = pick_index(lfsr_nib, idx_q, N_MOLES);
        mole_d = N_MOLES'(1) << idx_d;
    end

    // Game FSM with registered outputs; time_up overrides every in-game move
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            score_q      <= '0;
            lives_q      <= LIVES_INIT;
            mole_q       <= '0;
            idx_q        <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
        end else begin
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    mole_q <= '0;
                    if (start_rise) begin
                        score_q <= '0;
                        lives_q <= LIVES_INIT;
                        state_q <= ST_GAP;
                        cnt_q   <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (time_up_q) begin
                        state_q <= ST_OVER;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_SHOW;
                        cnt_q   <= SHOW_LOAD;
                        idx_q   <= idx_d;
                        mole_q  <= mole_d;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_SHOW: begin
                    if (time_up_q) begin
                        state_q <= ST_OVER;
                        cnt_q   <= '0;
                        mole_q  <= '0;
                    end else if (mole_hit) begin
                        // Lit bit wins even if stray buttons are pressed too
                        state_q     <= ST_HIT;
                        cnt_q       <= '0;
                        mole_q      <= '0;
                        hit_pulse_q <= 1'b1;
                        if (score_q != '1) begin
                            score_q <= score_q + SCORE_ONE;
                        end
                    end else if (any_whack || (cnt_q == '0)) begin
                        state_q      <= ST_MISS;
                        cnt_q        <= '0;
                        mole_q       <= '0;
                        miss_pulse_q <= 1'b1;
                        lives_q      <= (lives_q != 4'd0) ? (lives_q - 4'd1) : 4'd0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_HIT: begin
                    if (time_up_q) begin
                        state_q <= ST_OVER;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= ST_GAP;
                        cnt_q   <= GAP_LOAD;
                    end
                end
                ST_MISS: begin
                    // lives_q already holds the decremented count here
                    if (time_up_q || (lives_q == 4'd0)) begin
                        state_q <= ST_OVER;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= ST_GAP;
                        cnt_q   <= GAP_LOAD;
                    end
                end
                ST_OVER: begin
                    mole_q <= '0;
                    if (start_rise) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    mole_q  <= '0;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign mole       = mole_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;

endmodule
